// File: rtl/alu_issue_wb.sv
// Operand-issue and writeback stage around a registered ALU.
// Holds the architectural register file and sequences IDLE -> ISSUE -> CAPTURE per micro-op.
module alu_issue_wb #(
    parameter int NREGS = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_op,
    input  logic [AW-1:0] in_rd,
    input  logic [AW-1:0] in_rn,
    input  logic [AW-1:0] in_rm,
    input  logic          in_imm_en,
    input  logic [7:0]    in_imm,
    output logic [4:0]    alu_instruction,
    output logic [31:0]   alu_num1,
    output logic [31:0]   alu_num2,
    input  logic [31:0]   alu_result,
    input  logic [3:0]    alu_flags,
    output logic          wb_valid,
    output logic [AW-1:0] wb_rd,
    output logic [31:0]   wb_data,
    output logic [3:0]    flags_out,
    output logic          op_err,
    input  logic [AW-1:0] dbg_addr,
    output logic [31:0]   dbg_data
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    localparam logic [4:0] OP_CMP = 5'd18;

    state_t        state_q, state_d;
    logic [4:0]    op_q, op_d;
    logic [AW-1:0] rd_q, rd_d, rn_q, rn_d, rm_q, rm_d;
    logic          imm_en_q, imm_en_d;
    logic [7:0]    imm_q, imm_d;
    logic [31:0]   regs_q [NREGS];
    logic [31:0]   regs_d [NREGS];
    logic          wb_valid_q, wb_valid_d;
    logic [AW-1:0] wb_rd_q, wb_rd_d;
    logic [31:0]   wb_data_q, wb_data_d;
    logic [3:0]    flags_q, flags_d;
    logic          op_err_q, op_err_d;

    logic          accept;
    logic          op_ok;
    logic [31:0]   rn_val, rm_val, dbg_val;

    assign accept = in_valid && in_ready;
    assign op_ok  = (op_q >= 5'd1) && (op_q <= OP_CMP);

    // Indices at or above NREGS read as zero.
    always_comb begin
        rn_val  = '0;
        rm_val  = '0;
        dbg_val = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (rn_q == AW'(i))     rn_val  = regs_q[i];
            if (rm_q == AW'(i))     rm_val  = regs_q[i];
            if (dbg_addr == AW'(i)) dbg_val = regs_q[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (in_valid) state_d = S_ISSUE;
            S_ISSUE:   state_d = S_CAPTURE;
            S_CAPTURE: state_d = in_valid ? S_ISSUE : S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Opcode and operands are only non-zero while in ISSUE, so the ALU sees exactly one edge.
    always_comb begin
        in_ready        = (state_q != S_ISSUE);
        alu_instruction = 5'd0;
        alu_num1        = '0;
        alu_num2        = '0;
        if (state_q == S_ISSUE) begin
            alu_instruction = op_ok ? op_q : 5'd0;
            alu_num1        = rn_val;
            alu_num2        = imm_en_q ? {24'b0, imm_q} : rm_val;
        end
    end

    always_comb begin
        op_d       = op_q;
        rd_d       = rd_q;
        rn_d       = rn_q;
        rm_d       = rm_q;
        imm_en_d   = imm_en_q;
        imm_d      = imm_q;
        regs_d     = regs_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        flags_d    = flags_q;
        op_err_d   = 1'b0;
        if (accept) begin
            op_d     = in_op;
            rd_d     = in_rd;
            rn_d     = in_rn;
            rm_d     = in_rm;
            imm_en_d = in_imm_en;
            imm_d    = in_imm;
        end
        if (state_q == S_CAPTURE) begin
            if (op_ok) begin
                flags_d = alu_flags;
                if (op_q != OP_CMP) begin
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_data_d  = alu_result;
                    for (int i = 0; i < NREGS; i++) begin
                        if (rd_q == AW'(i)) regs_d[i] = alu_result;
                    end
                end
            end else begin
                op_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= '0;
            rd_q       <= '0;
            rn_q       <= '0;
            rm_q       <= '0;
            imm_en_q   <= 1'b0;
            imm_q      <= '0;
            regs_q     <= '{default: '0};
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            flags_q    <= '0;
            op_err_q   <= 1'b0;
        end else begin
            op_q       <= op_d;
            rd_q       <= rd_d;
            rn_q       <= rn_d;
            rm_q       <= rm_d;
            imm_en_q   <= imm_en_d;
            imm_q      <= imm_d;
            regs_q     <= regs_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            flags_q    <= flags_d;
            op_err_q   <= op_err_d;
        end
    end

    assign wb_valid  = wb_valid_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign flags_out = flags_q;
    assign op_err    = op_err_q;
    assign dbg_data  = dbg_val;

endmodule

// File: tb/tb_alu_issue_wb.sv
// Bench for alu_issue_wb: behavioural registered ALU, sequential reference of the register file,
// directed vector table, back-to-back and reset sequences, then randomized micro-ops.
module tb_alu_issue_wb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_op = '0;
    logic [3:0]  in_rd = '0, in_rn = '0, in_rm = '0;
    logic        in_imm_en = 1'b0;
    logic [7:0]  in_imm = '0;
    logic [4:0]  alu_instruction;
    logic [31:0] alu_num1, alu_num2;
    logic [31:0] alu_result;
    logic [3:0]  alu_flags;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic [3:0]  flags_out;
    logic        op_err;
    logic [3:0]  dbg_addr = '0;
    logic [31:0] dbg_data;

    int checks = 0;
    int errors = 0;
    int wb_cnt = 0, err_cnt = 0, issue_cnt = 0, legal_cnt = 0;

    alu_issue_wb #(.NREGS(16), .AW(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm),
        .in_imm_en(in_imm_en), .in_imm(in_imm),
        .alu_instruction(alu_instruction), .alu_num1(alu_num1), .alu_num2(alu_num2),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .flags_out(flags_out), .op_err(op_err),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // Returns {V,C,Z,N, result}; C is kept for ops that do not produce a carry.
    function automatic logic [35:0] alu_fn(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic cin);
        logic [32:0] s;
        logic [31:0] r;
        logic        c, v;
        c = cin;
        v = 1'b0;
        case (op)
            5'd5: begin
                s = {1'b0, a} + {1'b0, b} + {32'b0, cin};
                r = s[31:0]; c = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            5'd6: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0]; c = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            5'd8, 5'd18: begin
                r = a - b; c = (a >= b);
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            5'd1: r = a & b;
            5'd2: r = a | b;
            5'd3: r = a ^ b;
            default: r = a + (b ^ {27'b0, op});
        endcase
        return {v, c, (r == 32'd0), r[31], r};
    endfunction

    // Behavioural ALU: registers result/flags on the edge where an opcode is presented.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_result <= '0;
            alu_flags  <= '0;
        end else if (alu_instruction != 5'd0) begin
            {alu_flags, alu_result} <= alu_fn(alu_instruction, alu_num1, alu_num2, alu_flags[2]);
        end
    end

    always @(posedge clk) if (!rst && alu_instruction != 5'd0) issue_cnt++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: ops execute in acceptance order against a plain array.
    typedef struct {
        logic        err;
        logic [3:0]  rd;
        logic [31:0] data;
        logic [3:0]  flags;
    } ev_t;
    ev_t         exp_q[$];
    logic [31:0] ref_regs [16];
    logic        ref_c = 1'b0;

    function automatic logic is_legal(input logic [4:0] op);
        return (op >= 5'd1) && (op <= 5'd18);
    endfunction

    task automatic ref_exec(input logic [4:0] op, input logic [3:0] rd, input logic [3:0] rn,
                            input logic [3:0] rm, input logic imm_en, input logic [7:0] imm);
        logic [35:0] r;
        logic [31:0] b;
        ev_t e;
        b = imm_en ? {24'b0, imm} : ref_regs[rm];
        if (is_legal(op)) begin
            legal_cnt++;
            r = alu_fn(op, ref_regs[rn], b, ref_c);
            ref_c = r[34];
            if (op != 5'd18) begin
                ref_regs[rd] = r[31:0];
                e = '{1'b0, rd, r[31:0], r[35:32]};
                exp_q.push_back(e);
            end
        end else begin
            e = '{1'b1, 4'd0, 32'd0, 4'd0};
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (wb_valid || op_err)) begin
            if (wb_valid) wb_cnt++;
            if (op_err) err_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {30'b0, wb_valid, op_err}, 32'd0);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk("pulse_kind", {30'b0, wb_valid, op_err}, {30'b0, !e.err, e.err});
                if (!e.err) begin
                    chk("wb_rd", {28'b0, wb_rd}, {28'b0, e.rd});
                    chk("wb_data", wb_data, e.data);
                    chk("wb_flags", {28'b0, flags_out}, {28'b0, e.flags});
                end
            end
        end
    end

    logic rdy_log[$];

    // Called at posedge+1; returns at posedge+1 after the accepting edge with in_valid dropped.
    task automatic send(input logic [4:0] op, input logic [3:0] rd, input logic [3:0] rn,
                        input logic [3:0] rm, input logic imm_en, input logic [7:0] imm);
        logic done;
        done = 1'b0;
        in_valid = 1'b1; in_op = op; in_rd = rd; in_rn = rn; in_rm = rm;
        in_imm_en = imm_en; in_imm = imm;
        for (int t = 0; t < 8 && !done; t++) begin
            @(negedge clk);
            rdy_log.push_back(in_ready);
            done = in_ready;
            @(posedge clk);
            if (done) ref_exec(op, rd, rn, rm, imm_en, imm);
            #1;
        end
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic dbg_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
        dbg_addr = a;
        #1;
        chk(name, dbg_data, exp);
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [3:0]  rd, rn, rm;
        logic        imm_en;
        logic [7:0]  imm;
        logic        exp_wb;
        logic [31:0] exp_data;
        logic        exp_err;
        logic [3:0]  exp_flags;
    } vec_t;
    vec_t        vecs[11];
    logic [31:0] tbl_regs [16];

    initial begin
        int wb0, er0, is0;
        logic [31:0] opnd2;
        vecs[0]  = '{5'd6,  4'd1, 4'd0, 4'd0, 1'b1, 8'd5,  1'b1, 32'd5,         1'b0, 4'b0000};
        vecs[1]  = '{5'd6,  4'd2, 4'd1, 4'd0, 1'b1, 8'd7,  1'b1, 32'd12,        1'b0, 4'b0000};
        vecs[2]  = '{5'd8,  4'd3, 4'd2, 4'd0, 1'b1, 8'd12, 1'b1, 32'd0,         1'b0, 4'b0110};
        vecs[3]  = '{5'd6,  4'd4, 4'd3, 4'd0, 1'b1, 8'd1,  1'b1, 32'd1,         1'b0, 4'b0000};
        vecs[4]  = '{5'd18, 4'd0, 4'd2, 4'd0, 1'b1, 8'd12, 1'b0, 32'd0,         1'b0, 4'b0110};
        vecs[5]  = '{5'd0,  4'd5, 4'd0, 4'd0, 1'b1, 8'd0,  1'b0, 32'd0,         1'b1, 4'b0110};
        vecs[6]  = '{5'd25, 4'd5, 4'd1, 4'd2, 1'b0, 8'd0,  1'b0, 32'd0,         1'b1, 4'b0110};
        vecs[7]  = '{5'd8,  4'd6, 4'd0, 4'd0, 1'b1, 8'd1,  1'b1, 32'hFFFF_FFFF, 1'b0, 4'b0001};
        vecs[8]  = '{5'd6,  4'd7, 4'd6, 4'd0, 1'b1, 8'd1,  1'b1, 32'd0,         1'b0, 4'b0110};
        vecs[9]  = '{5'd5,  4'd8, 4'd4, 4'd0, 1'b1, 8'd0,  1'b1, 32'd2,         1'b0, 4'b0000};
        vecs[10] = '{5'd3,  4'd9, 4'd1, 4'd2, 1'b0, 8'd0,  1'b1, 32'd9,         1'b0, 4'b0000};
        for (int i = 0; i < 16; i++) begin
            ref_regs[i] = '0;
            tbl_regs[i] = '0;
        end

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_alu_instr", {27'b0, alu_instruction}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
        chk("reset_alu_instr", {27'b0, alu_instruction}, 32'd0);
        chk("reset_num1", alu_num1, 32'd0);
        chk("reset_num2", alu_num2, 32'd0);
        chk("reset_wb", {26'b0, wb_valid, op_err, wb_rd}, 32'd0);
        chk("reset_wb_data", wb_data, 32'd0);
        chk("reset_flags", {28'b0, flags_out}, 32'd0);
        dbg_chk("reset_dbg", 4'd3, 32'd0);

        for (int v = 0; v < 11; v++) begin
            wb0 = wb_cnt; er0 = err_cnt; is0 = issue_cnt;
            send(vecs[v].op, vecs[v].rd, vecs[v].rn, vecs[v].rm, vecs[v].imm_en, vecs[v].imm);
            opnd2 = vecs[v].imm_en ? {24'b0, vecs[v].imm} : tbl_regs[vecs[v].rm];
            chk($sformatf("v%0d_issue_op", v), {27'b0, alu_instruction},
                is_legal(vecs[v].op) ? {27'b0, vecs[v].op} : 32'd0);
            chk($sformatf("v%0d_num1", v), alu_num1, tbl_regs[vecs[v].rn]);
            chk($sformatf("v%0d_num2", v), alu_num2, opnd2);
            repeat (3) @(posedge clk);
            #1;
            chk($sformatf("v%0d_wb_pulses", v), wb_cnt - wb0, {31'b0, vecs[v].exp_wb});
            chk($sformatf("v%0d_err_pulses", v), err_cnt - er0, {31'b0, vecs[v].exp_err});
            chk($sformatf("v%0d_issue_edges", v), issue_cnt - is0, {31'b0, is_legal(vecs[v].op)});
            chk($sformatf("v%0d_flags", v), {28'b0, flags_out}, {28'b0, vecs[v].exp_flags});
            chk($sformatf("v%0d_idle_num", v), alu_num1 | alu_num2, 32'd0);
            if (vecs[v].exp_wb) begin
                tbl_regs[vecs[v].rd] = vecs[v].exp_data;
                chk($sformatf("v%0d_wb_data_hold", v), wb_data, vecs[v].exp_data);
            end
            dbg_chk($sformatf("v%0d_dbg", v), vecs[v].rd, tbl_regs[vecs[v].rd]);
        end
        dbg_chk("cmp_r2_kept", 4'd2, 32'd12);

        // Back-to-back: the second op reads R9 written at the edge that issues it.
        rdy_log.delete();
        send(5'd8, 4'd9, 4'd2, 4'd0, 1'b1, 8'd12);
        send(5'd6, 4'd10, 4'd9, 4'd0, 1'b1, 8'd1);
        @(negedge clk);
        rdy_log.push_back(in_ready);
        chk("b2b_ready_len", rdy_log.size(), 32'd4);
        if (rdy_log.size() == 4)
            chk("b2b_ready_pat", {28'b0, rdy_log[0], rdy_log[1], rdy_log[2], rdy_log[3]}, 32'b1010);
        repeat (3) @(posedge clk);
        #1;
        dbg_chk("b2b_r9", 4'd9, 32'd0);
        dbg_chk("b2b_r10", 4'd10, 32'd1);

        // Randomized micro-ops with optional idle gaps.
        for (int n = 0; n < 300; n++) begin
            logic [4:0] op;
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            op = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 18));
            send(op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        end
        for (int t = 0; t < 10 && exp_q.size() != 0; t++) @(posedge clk);
        #1;
        chk("rand_drained", exp_q.size(), 32'd0);
        chk("rand_issue_total", issue_cnt, legal_cnt);
        for (int i = 0; i < 16; i++) dbg_chk($sformatf("rand_r%0d", i), 4'(i), ref_regs[i]);

        // Reset during ISSUE discards the op.
        wb0 = wb_cnt; er0 = err_cnt;
        send(5'd6, 4'd5, 4'd0, 4'd0, 1'b1, 8'h33);
        chk("rst_mid_issuing", {27'b0, alu_instruction}, 32'd6);
        chk("rst_mid_num2", alu_num2, 32'h33);
        rst = 1'b1;
        #1;
        chk("rst_mid_instr_async", {27'b0, alu_instruction}, 32'd0);
        chk("rst_mid_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_mid_nums", alu_num1 | alu_num2, 32'd0);
        exp_q.delete();
        for (int i = 0; i < 16; i++) ref_regs[i] = '0;
        ref_c = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {31'b0, in_ready}, 32'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("rst_mid_no_wb", wb_cnt - wb0, 32'd0);
        chk("rst_mid_no_err", err_cnt - er0, 32'd0);
        chk("post_rst_outs", {22'b0, wb_valid, op_err, wb_rd, flags_out}, 32'd0);
        chk("post_rst_wb_data", wb_data, 32'd0);
        dbg_chk("post_rst_r5", 4'd5, 32'd0);
        dbg_chk("post_rst_r2", 4'd2, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_wb.md
# alu_issue_wb

Operand-issue and writeback stage wrapped around the ALU. It accepts decoded micro-ops over a valid/ready handshake and holds the architectural register file. It drives the ALU's opcode and operand inputs for exactly one cycle, then captures the ALU's registered result and flags one cycle later. It writes the result back to the register file and exposes a writeback strobe for downstream trace and debug.

## Interface
- NREGS, 16, number of 32-bit architectural registers
- AW, 4, register address width (clog2 NREGS)
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  micro-op present
- in_ready  out  1  stage can accept a micro-op this cycle
- in_op  in  5  ALU opcode: 1..18 legal, 0 and 19..31 illegal
- in_rd, in_rn, in_rm  in  AW  destination, operand-1 and operand-2 register indices
- in_imm_en  in  1  1: operand 2 is in_imm zero-extended to 32 bits; 0: operand 2 is R[rm]
- in_imm  in  8  immediate value
- alu_instruction  out  5  ALU opcode; 0 (NOP) except during ISSUE
- alu_num1, alu_num2  out  32  ALU operands
- alu_result  in  32  registered ALU result
- alu_flags  in  4  registered ALU flags {V,C,Z,N}, bit 0 = N
- wb_valid  out  1  one-cycle pulse when a register is written
- wb_rd  out  AW  index written
- wb_data  out  32  value written
- flags_out  out  4  last captured ALU flags
- op_err  out  1  one-cycle pulse when an illegal opcode retires
- dbg_addr  in  AW  debug read index
- dbg_data  out  32  combinational R[dbg_addr]

## Operation
- FSM states: IDLE, ISSUE, CAPTURE.
  - IDLE: in_ready=1. On in_valid, latch op/rd/rn/rm/imm_en/imm and go to ISSUE.
  - ISSUE: in_ready=0. Drive alu_instruction = latched op if legal, else 0. Drive alu_num1 = R[rn]. Drive alu_num2 = imm_en ? {24'b0,imm} : R[rm]. Next state is always CAPTURE.
  - CAPTURE: alu_instruction=0. Sample alu_result and alu_flags.
    - Legal op other than CMP (ops 1..17): write R[rd] <= alu_result and pulse wb_valid with wb_rd/wb_data.
    - CMP (18): no register write.
    - Illegal op: no write, pulse op_err.
    - flags_out <= alu_flags for every legal op.
    - in_ready=1. On in_valid, latch the new op and go to ISSUE; otherwise go to IDLE.
- The opcode is presented for exactly one rising edge. This is mandatory: ADCS/SBCS consume the ALU carry, and a repeated edge would double-execute them.
- Operand values are not held outside ISSUE; hold alu_num1/alu_num2 at 0 in IDLE and CAPTURE.
- Hazards: the register write in CAPTURE commits at the same edge that moves the next op into ISSUE. That op therefore reads the updated value, with no forwarding needed, including rd==rn or rd==rm.
- Register index ≥ NREGS (only possible if NREGS < 2^AW): reads return 0 and writes are dropped. wb_valid still pulses.

## Timing
- Reset values: state=IDLE, all registers 0, in_ready=1, alu_instruction=0, alu_num1=alu_num2=0, wb_valid=0, wb_rd=0, wb_data=0, flags_out=0, op_err=0.
- Handshake at edge E0 (IDLE). ISSUE during cycle E0..E1; the ALU registers at E1. CAPTURE during E1..E2; the write commits at E2.
- wb_valid is high for the cycle E2..E3. wb_rd/wb_data are registered alongside it and hold their value until the next pulse.
- Latency from accept to register update: 2 edges. Maximum throughput: 1 op per 2 cycles (back-to-back accept in CAPTURE).
- in_ready is combinational from state only, never from in_valid.
- rst asserted mid-operation (ISSUE or CAPTURE) forces IDLE immediately. The in-flight op is discarded with no write, no wb_valid and no op_err, and alu_instruction drops to 0 asynchronously.
- dbg_data reflects writes from the edge after commit.

## Test plan
- Reset, then ADDS (op 6) with R1=5 (seeded via prior ops) and imm 7 into rd=2: alu_instruction=6 for exactly one cycle, alu_num2=7. After 2 edges R2=12, wb_valid pulse with wb_rd=2, wb_data=12, and dbg_data(2)=12.
- Back-to-back ops with in_valid held: SUB (op 8) R3=R2-imm 12, then ADDS R4=R3+imm 1 accepted in CAPTURE. R3=0 and flags_out Z=1. R4=1, proving the hazard-free read. in_ready pattern is 1,0,1,0.
- CMP (op 18) R2 vs imm 12: no wb_valid, registers unchanged, flags_out Z=1.
- Illegal op 0 and op 25: alu_instruction stays 0, op_err pulses once per op, no register write.
- ADCS (op 5) after an ADDS 0xFFFFFFFF+1 that sets C: monitor counts exactly one edge with alu_instruction=5, and the result is 1+carry as expected.
- rst asserted during ISSUE of an ADDS into R5=0x33: R5 stays 0, no wb_valid, all outputs at reset values, in_ready=1 immediately after rst deasserts.
